// File: rtl/dm_arbiter.sv
// Data-memory arbiter between the CPU DM stage and an external loader/debug port.
// Optional burst locking for the external port is compiled in with MEM_ARB_LOCK_EN.
module dm_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int STARVE_MAX = 4,
  parameter int LOCK_MAX   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_stall,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
`ifdef MEM_ARB_LOCK_EN
  input  logic          ext_lock,
`endif
  output logic          ext_gnt,
  output logic          ext_rvalid,
  output logic [DW-1:0] ext_rdata,
  output logic          dm_we,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_din,
  input  logic [DW-1:0] dm_dout,
  output logic          busy
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    CPU_OWN,
    EXT_OWN
`ifdef MEM_ARB_LOCK_EN
    , LOCK
`endif
  } state_t;

  state_t        state, next_state;
  logic [SW-1:0] starve_cnt;
  logic          starve_hit;
  logic          rd_cpu, rd_ext;
  logic          hold, force_cpu, lock_pri;
  logic          cpu_win, ext_win;

`ifdef MEM_ARB_LOCK_EN
  localparam int LW = $clog2(LOCK_MAX + 1);
  logic [LW-1:0] lock_cnt, lock_cnt_d;
`endif

  assign starve_hit = (starve_cnt == SW'(STARVE_MAX));

  always_comb begin
    hold      = 1'b0;
    force_cpu = 1'b0;
    lock_pri  = 1'b0;
`ifdef MEM_ARB_LOCK_EN
    // A burst that reached LOCK_MAX hands the next cycle to the CPU and may not relock in it.
    force_cpu = (state == LOCK) && (lock_cnt == LW'(LOCK_MAX));
    hold      = (state == LOCK) && ext_lock && !force_cpu;
    lock_pri  = ext_req && ext_lock && !force_cpu;
`endif
    cpu_win = 1'b0;
    ext_win = 1'b0;
    if (hold) begin
      ext_win = ext_req;
    end else if (force_cpu) begin
      cpu_win = cpu_req;
      ext_win = ext_req & ~cpu_req;
    end else if (lock_pri) begin
      ext_win = 1'b1;
    end else if (cpu_req && ext_req) begin
      ext_win = starve_hit;
      cpu_win = !starve_hit;
    end else begin
      cpu_win = cpu_req;
      ext_win = ext_req;
    end
    // NOTE: grants are gated by rst so every output is 0 while reset is held, not just the flops.
    cpu_gnt   = rst & cpu_win;
    ext_gnt   = rst & ext_win;
    cpu_stall = rst & cpu_req & ~cpu_win;
  end

  always_comb begin
    next_state = IDLE;
    if (cpu_gnt)                       next_state = CPU_OWN;
`ifdef MEM_ARB_LOCK_EN
    else if (hold || (ext_gnt && lock_pri)) next_state = LOCK;
`endif
    else if (ext_gnt)                  next_state = EXT_OWN;
  end

`ifdef MEM_ARB_LOCK_EN
  always_comb begin
    lock_cnt_d = '0;
    if (next_state == LOCK) lock_cnt_d = (state == LOCK) ? lock_cnt + 1'b1 : LW'(1);
  end
`endif

  always_comb begin
    dm_we   = 1'b0;
    dm_addr = '0;
    dm_din  = '0;
    if (cpu_gnt) begin
      dm_we   = cpu_we;
      dm_addr = cpu_addr;
      dm_din  = cpu_wdata;
    end else if (ext_gnt) begin
      dm_we   = ext_we;
      dm_addr = ext_addr;
      dm_din  = ext_wdata;
    end
  end

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      rd_cpu     <= 1'b0;
      rd_ext     <= 1'b0;
    end else begin
      state  <= next_state;
      rd_cpu <= cpu_gnt & ~cpu_we;
      rd_ext <= ext_gnt & ~ext_we;
      if (ext_req && !ext_gnt) starve_cnt <= starve_hit ? starve_cnt : starve_cnt + 1'b1;
      else                     starve_cnt <= '0;
    end
  end

`ifdef MEM_ARB_LOCK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lock_cnt <= '0;
    else      lock_cnt <= lock_cnt_d;
  end
`endif

  assign cpu_rvalid = rd_cpu;
  assign ext_rvalid = rd_ext;
  assign cpu_rdata  = rd_cpu ? dm_dout : '0;
  assign ext_rdata  = rd_ext ? dm_dout : '0;
  assign busy       = cpu_gnt | ext_gnt | rd_cpu | rd_ext;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model (burst tests need MEM_ARB_LOCK_EN).
module tb_dm_arbiter;

  localparam int AW = 8, DW = 8, STARVE_MAX = 4, LOCK_MAX = 16;

  logic clk = 1'b0, rst;
  logic cpu_req, cpu_we, ext_req, ext_we, ext_lock;
  logic [AW-1:0] cpu_addr, ext_addr, dm_addr;
  logic [DW-1:0] cpu_wdata, ext_wdata, cpu_rdata, ext_rdata, dm_din, dm_dout;
  logic cpu_gnt, cpu_stall, cpu_rvalid, ext_gnt, ext_rvalid, dm_we, busy;

  int n_checks = 0, n_errors = 0;

  dm_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
`ifdef MEM_ARB_LOCK_EN
    .ext_lock(ext_lock),
`endif
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_din(dm_din), .dm_dout(dm_dout), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous-read data memory driven by the DUT's memory port.
  logic [DW-1:0] mem [2**AW];
  always @(posedge clk) begin
    if (dm_we) mem[dm_addr] <= dm_din;
    dm_dout <= mem[dm_addr];
  end

  // Reference model: who waited how long, how long the burst has run, which read returns next.
  logic [DW-1:0] ref_mem [2**AW];
  int   m_wait, m_len, m_pend;
  bit   m_burst;
  logic [DW-1:0] m_pval;
  bit   last_cg, last_eg, last_stall, last_dmwe;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_wait = 0; m_len = 0; m_burst = 0; m_pend = 0; m_pval = '0;
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input bit cr, input bit cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                      input bit er, input bit ew, input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                      input bit el);
    bit cg, eg, el_eff, nb;
    int nl, nw, np;
    logic [DW-1:0] nv;
    logic exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_din;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    ext_req = er; ext_we = ew; ext_addr = ea; ext_wdata = ed; ext_lock = el;
`ifdef MEM_ARB_LOCK_EN
    el_eff = el;
`else
    el_eff = 1'b0;
`endif
    cg = 0; eg = 0; nb = 0; nl = 0;
    if (m_burst && m_len >= LOCK_MAX) begin
      cg = cr; eg = er && !cr;
    end else if (m_burst && el_eff) begin
      eg = er; nb = 1; nl = m_len + 1;
    end else if (er && el_eff) begin
      eg = 1; nb = 1; nl = 1;
    end else if (cr && er) begin
      if (m_wait >= STARVE_MAX) eg = 1; else cg = 1;
    end else begin
      cg = cr; eg = er;
    end
    exp_we = 0; exp_addr = '0; exp_din = '0;
    if (cg) begin exp_we = cw; exp_addr = ca; exp_din = cd; end
    if (eg) begin exp_we = ew; exp_addr = ea; exp_din = ed; end
    #1;
    check("cpu_gnt", cpu_gnt, cg);
    check("ext_gnt", ext_gnt, eg);
    check("cpu_stall", cpu_stall, cr && !cg);
    check("dm_we", dm_we, exp_we);
    check("dm_addr", dm_addr, exp_addr);
    check("dm_din", dm_din, exp_din);
    check("cpu_rvalid", cpu_rvalid, m_pend == 1);
    check("ext_rvalid", ext_rvalid, m_pend == 2);
    check("cpu_rdata", cpu_rdata, (m_pend == 1) ? m_pval : '0);
    check("ext_rdata", ext_rdata, (m_pend == 2) ? m_pval : '0);
    check("busy", busy, cg || eg || m_pend != 0);
    last_cg = cpu_gnt; last_eg = ext_gnt; last_stall = cpu_stall; last_dmwe = dm_we;
    nw = (er && !eg) ? ((m_wait < STARVE_MAX) ? m_wait + 1 : m_wait) : 0;
    np = 0; nv = '0;
    if (cg && !cw) begin np = 1; nv = ref_mem[ca]; end
    if (eg && !ew) begin np = 2; nv = ref_mem[ea]; end
    @(posedge clk);
    if (cg && cw) ref_mem[ca] = cd;
    if (eg && ew) ref_mem[ea] = ed;
    m_wait = nw; m_burst = nb; m_len = nl; m_pend = np; m_pval = nv;
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, '0, '0, 0, 0, '0, '0, 0);
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      mem[i] = DW'(i * 7 + 3);
      ref_mem[i] = DW'(i * 7 + 3);
    end
    model_reset();
    rst = 1'b0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h33; cpu_wdata = 8'hA5;
    ext_req = 1; ext_we = 1; ext_addr = 8'h44; ext_wdata = 8'h5A; ext_lock = 0;
    @(negedge clk); @(negedge clk);
    #1;
    check("rst0_cpu_gnt", cpu_gnt, 0);
    check("rst0_ext_gnt", ext_gnt, 0);
    check("rst0_stall", cpu_stall, 0);
    check("rst0_dm_we", dm_we, 0);
    check("rst0_dm_addr", dm_addr, 0);
    check("rst0_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;

    // First grant in the first cycle after release.
    step(1, 0, 8'h05, 8'h00, 0, 0, '0, '0, 0);
    check("first_gnt", last_cg, 1);
    idle();

    // Ext write then cpu read of the same location.
    step(0, 0, '0, '0, 1, 1, 8'h10, 8'h5A, 0);
    step(1, 0, 8'h10, 8'h00, 0, 0, '0, '0, 0);
    check("rd_cpu_rvalid", cpu_rvalid, 1);
    check("rd_cpu_rdata", cpu_rdata, 8'h5A);
    check("rd_ext_rvalid", ext_rvalid, 0);
    idle();

    // Alternating reads on consecutive cycles.
    step(1, 1, 8'h01, 8'h11, 0, 0, '0, '0, 0);
    step(0, 0, '0, '0, 1, 1, 8'h02, 8'h22, 0);
    step(1, 0, 8'h01, 8'h00, 0, 0, '0, '0, 0);
    check("alt_cpu_rvalid", cpu_rvalid, 1);
    check("alt_cpu_rdata", cpu_rdata, 8'h11);
    step(0, 0, '0, '0, 1, 0, 8'h02, 8'h00, 0);
    check("alt_ext_rvalid", ext_rvalid, 1);
    check("alt_ext_rdata", ext_rdata, 8'h22);
    check("alt_no_overlap", cpu_rvalid, 0);
    idle();

    // Contention: cpu 1-4, ext 5, cpu 6-9, ext 10; stall only on ext cycles.
    for (int i = 0; i < 10; i++) begin
      step(1, 0, AW'(8'h20 + i), 8'h00, 1, 1, AW'(8'h60 + i), DW'(8'hC0 + i), 0);
      check("cont_ext_gnt", last_eg, (i == 4 || i == 9));
      check("cont_stall", last_stall, (i == 4 || i == 9));
      check("cont_dm_we", last_dmwe, (i == 4 || i == 9));
    end
    idle();

    // Reset asserted while a cpu read return is pending.
    step(1, 0, 8'h10, 8'h00, 0, 0, '0, '0, 0);
    rst = 1'b0;
    #1;
    check("rstmid_cpu_rvalid", cpu_rvalid, 0);
    check("rstmid_cpu_rdata", cpu_rdata, 0);
    check("rstmid_cpu_gnt", cpu_gnt, 0);
    check("rstmid_stall", cpu_stall, 0);
    check("rstmid_busy", busy, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    step(1, 0, 8'h10, 8'h00, 0, 0, '0, '0, 0);
    check("rstmid_first_gnt", last_cg, 1);
    idle();

`ifdef MEM_ARB_LOCK_EN
    // Locked burst: ext 16 cycles, forced cpu cycle 17, ext relocks 18.
    for (int i = 0; i < 20; i++) begin
      step(1, 0, AW'(i), 8'h00, 1, 0, AW'(8'h80 + i), 8'h00, 1);
      check("lock_ext_gnt", last_eg, (i != 16));
      check("lock_cpu_gnt", last_cg, (i == 16));
    end
    idle();
`endif

    // Randomized traffic on a small address window to force reuse.
    for (int i = 0; i < 400; i++) begin
      bit el_r;
      el_r = ($urandom_range(0, 3) == 0);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom),
           el_r);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: AW, 8, address width; DW, 8, data width; STARVE_MAX, 4, max consecutive cycles ext may be denied; LOCK_MAX, 16, max locked-burst length.
REQ-002 Ports SHALL be (name, direction, width, meaning); one clock; reset is asynchronous and active-low:
- clk  in  1  clock, rising edge
- rst  in  1  async reset, active-low
- cpu_req  in  1  pipeline DM-stage access request
- cpu_we  in  1  cpu write (1) / read (0)
- cpu_addr  in  AW  cpu address
- cpu_wdata  in  DW  cpu write data
- cpu_gnt  out  1  cpu access issued this cycle
- cpu_stall  out  1  cpu_req & ~cpu_gnt; freezes pipeline
- cpu_rvalid  out  1  cpu read data valid
- cpu_rdata  out  DW  cpu read data
- ext_req, ext_we, ext_addr, ext_wdata  in  1/1/AW/DW  external loader/debug port request
- ext_lock  in  1  burst hold request (MEM_ARB_LOCK_EN only)
- ext_gnt, ext_rvalid, ext_rdata  out  1/1/DW  ext grant and read return
- dm_we  out  1  data-memory write enable
- dm_addr  out  AW  data-memory address
- dm_din  out  DW  data-memory write data
- dm_dout  in  DW  data-memory read data, valid one cycle after address
- busy  out  1  access issued this cycle or read return pending

Function
REQ-003 At most one of cpu_gnt/ext_gnt SHALL be high per cycle; grants are combinational from current requests and registered state.
REQ-004 FSM states SHALL be IDLE, CPU_OWN, EXT_OWN, LOCK; state records the owner of the access issued last cycle (IDLE if none).
REQ-005 Default priority SHALL be CPU; with both requesting, CPU wins unless starve_cnt == STARVE_MAX, then ext wins.
REQ-006 starve_cnt SHALL increment (saturating at STARVE_MAX) each cycle ext_req & ~ext_gnt, and clear on ext_gnt or ~ext_req.
REQ-007 dm_addr/dm_din SHALL mux the granted requester's addr/wdata; dm_we = granted & requester's we; with no grant dm_we = 0, dm_addr/dm_din = 0.
REQ-008 A read granted in cycle N SHALL produce requester's rvalid = 1 and rdata = dm_dout in cycle N+1 only; owner tag registered at N; writes produce no rvalid.
REQ-009 rdata of the non-owning port SHALL read 0; rvalid of both ports SHALL never be high together.
REQ-010 Back-to-back grants to alternating requesters SHALL be allowed every cycle; read return of N and issue of N+1 overlap without loss.
REQ-011 cpu_stall SHALL be exactly cpu_req & ~cpu_gnt, combinational.
REQ-012 Requests dropped before grant SHALL have no side effect; no request is queued internally.

Reset
REQ-013 rst low SHALL asynchronously force state IDLE, starve_cnt 0, lock_cnt 0, pending-read tag cleared; all outputs 0 while rst low.
REQ-014 A read granted in the cycle reset asserts SHALL NOT produce rvalid after reset release.
REQ-015 First grant SHALL be possible in the first rising edge cycle after rst deasserts.

Configuration
REQ-016 Macro MEM_ARB_LOCK_EN SHALL compile in burst locking; without it, port ext_lock and state LOCK are absent and behaviour is REQ-003..015 only.
REQ-017 With MEM_ARB_LOCK_EN: ext_gnt & ext_lock enters LOCK; in LOCK ext wins every cycle it requests, cpu_gnt = 0; lock_cnt counts LOCK cycles.
REQ-018 LOCK SHALL exit on ~ext_lock or lock_cnt == LOCK_MAX; on LOCK_MAX exit CPU has absolute priority for the next cycle and relock is blocked that cycle.

Verification
REQ-019 Reset: rst=0 mid-read -> all outputs 0, no rvalid after release; first cpu_req after release -> cpu_gnt same cycle.
REQ-020 Contention: cpu_req and ext_req held high 10 cycles -> cpu granted cycles 1-4, ext granted cycle 5, cpu 6-9, ext 10 (STARVE_MAX=4).
REQ-021 Read return: ext write 0x5A to 0x10, then cpu read 0x10 -> cpu_rvalid next cycle, cpu_rdata = 0x5A, ext_rvalid = 0.
REQ-022 Alternation: cpu read 0x01 and ext read 0x02 on consecutive cycles -> rvalids on consecutive cycles, correct data each, no overlap.
REQ-023 Stall: cpu_req high while ext wins starvation slot -> cpu_stall = 1 that cycle only, dm_we follows ext_we.
REQ-024 Lock (MEM_ARB_LOCK_EN): ext_lock held 20 cycles with cpu_req high -> ext granted 16 cycles, cpu granted cycle 17, ext relocks cycle 18.
